instr_prefetch_unit: RTL and testbench

// - Fetch stage upstream of the single-cycle decode/register-file/execute core. It drives a

---
 rtl/instr_prefetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: drives a 1-cycle ROM and queues fetched codes for the core.
// Define PREFETCH_STATS_EN to add fetch_count / flush_count statistics ports.
module instr_prefetch_unit #(
    parameter int IW = 8,
    parameter int AW = 8,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr_code,
    output logic [AW-1:0] instr_pc,
    input  logic          branch_valid,
    input  logic [AW-1:0] branch_target
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]   fetch_count,
    output logic [7:0]    flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t state_q, state_d;

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] tag_pc;
    logic          inflight;
    logic          req_epoch;
    logic          epoch;

    logic [IW-1:0] code_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic stale;

    always_comb begin
        state_d = state_q;
        stale   = 1'b0;
        unique case (state_q)
            RUN: stale = 1'b0;
            REDIRECT: begin
                stale   = (req_epoch != epoch);
                state_d = RUN;
            end
        endcase
        if (branch_valid) state_d = REDIRECT;
    end

    // Credit check counts the in-flight fetch so a push can never hit a full queue.
    assign imem_req = Reset |
        (!branch_valid && (({1'b0, count} + {{CW{1'b0}}, inflight}) < FULL));
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign push        = inflight && !branch_valid && !stale;
    assign pop         = instr_valid && instr_ready && !branch_valid;

    always_ff @(posedge Clk) begin
        if (push) begin
            code_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= tag_pc;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= RUN;
            fetch_pc   <= RESET_PC;
            tag_pc     <= '0;
            inflight   <= 1'b0;
            req_epoch  <= 1'b0;
            epoch      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            instr_code <= '0;
            instr_pc   <= '0;
        end else begin
            state_q <= state_d;
            if (branch_valid) begin
                fetch_pc <= branch_target;
                inflight <= 1'b0;
                epoch    <= ~epoch;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= imem_req;
                if (imem_req) begin
                    tag_pc    <= fetch_pc;
                    req_epoch <= epoch;
                    fetch_pc  <= fetch_pc + 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                // Head registers track what will sit at rd_ptr after this edge.
                if (pop) begin
                    if (count > 1) begin
                        instr_code <= code_mem[rd_ptr + 1'b1];
                        instr_pc   <= pc_mem[rd_ptr + 1'b1];
                    end else if (push) begin
                        instr_code <= imem_rdata;
                        instr_pc   <= tag_pc;
                    end
                end else if (count == '0 && push) begin
                    instr_code <= imem_rdata;
                    instr_pc   <= tag_pc;
                end
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (imem_req && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
            if (branch_valid && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: queue model of the fetch stream plus a RESET_PC=0xFE wrap instance.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_code;
    logic [7:0] instr_pc;
    logic       branch_valid;
    logic [7:0] branch_target;

    logic       req2;
    logic [7:0] addr2;
    logic [7:0] rdata2;
    logic       valid2;
    logic [7:0] code2;
    logic [7:0] pc2;
    logic       ready2 = 1'b1;
    logic       br2 = 1'b0;
    logic [7:0] tgt2 = 8'h00;

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [7:0]  flush_count;
    logic [15:0] fetch_count2;
    logic [7:0]  flush_count2;
`endif

    logic [7:0] rom [256];

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    instr_prefetch_unit #(.IW(8), .AW(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .Clk(Clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_code(instr_code), .instr_pc(instr_pc),
        .branch_valid(branch_valid), .branch_target(branch_target)
`ifdef PREFETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    instr_prefetch_unit #(.IW(8), .AW(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut2 (
        .Clk(Clk), .Reset(Reset),
        .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr_ready(ready2),
        .instr_code(code2), .instr_pc(pc2),
        .branch_valid(br2), .branch_target(tgt2)
`ifdef PREFETCH_STATS_EN
        , .fetch_count(fetch_count2), .flush_count(flush_count2)
`endif
    );

    // Synchronous ROM: data for the address seen at an edge appears after it.
    always @(posedge Clk) begin
        imem_rdata <= rom[imem_addr];
        rdata2 <= rom[addr2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected delivery order is a queue of PCs; each PC carries rom[pc].
    logic [7:0] sb [$];
    bit         m_inflight = 0;
    logic [7:0] m_tag = 8'h00;
    logic [7:0] m_pc = 8'h00;
    bit         m_req = 1;
    int         m_fetch = 0;
    int         m_flush = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sb.delete();
            m_inflight = 0;
            m_pc = 8'h00;
            m_fetch = 0;
            m_flush = 0;
        end else if (branch_valid) begin
            sb.delete();
            m_inflight = 0;
            m_pc = branch_target;
            if (m_flush < 255) m_flush++;
        end else begin
            if (m_inflight) sb.push_back(m_tag);
            m_inflight = m_req;
            if (m_req) begin
                m_tag = m_pc;
                m_pc = m_pc + 8'h01;
                if (m_fetch < 65535) m_fetch++;
            end
        end
    end

    // Monitor: compares the head and issue outputs, pops the scoreboard on a handshake.
    int occ;
    always @(negedge Clk) begin
        if (Reset) begin
            check("rst_valid", instr_valid, 0);
            check("rst_req", imem_req, 1);
            check("rst_addr", imem_addr, 8'h00);
        end else begin
            occ = sb.size() + int'(m_inflight);
            m_req = !branch_valid && (occ < DEPTH);
            check("req", imem_req, m_req);
            if (m_req) check("addr", imem_addr, m_pc);
            check("valid", instr_valid, sb.size() != 0);
            if (instr_valid && sb.size() != 0) begin
                check("pc", instr_pc, sb[0]);
                check("code", instr_code, rom[sb[0]]);
                if (instr_ready && !branch_valid) void'(sb.pop_front());
            end
        end
`ifdef PREFETCH_STATS_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", flush_count, m_flush);
`endif
    end

    // Wrap instance: always ready, never branches, must stream FE,FF,00,01... without gaps.
    logic [7:0] e2 = 8'hFE;
    int cyc2 = 0;
    always @(negedge Clk) begin
        if (Reset) begin
            e2 = 8'hFE;
            cyc2 = 0;
            check("rst_valid2", valid2, 0);
        end else begin
            cyc2++;
            if (cyc2 >= 3) check("valid2", valid2, 1);
            if (valid2) begin
                check("pc2", pc2, e2);
                check("code2", code2, rom[e2]);
                e2 = e2 + 8'h01;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    int rp;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        instr_ready = 1'b1;
        branch_valid = 1'b0;
        branch_target = 8'h00;
        #1 Reset = 1'b1;
        step(3);
        check("rst_code", instr_code, 0);
        check("rst_pc", instr_pc, 0);
        Reset = 1'b0;
        step(20);

        Reset = 1'b1;
        step(1);
        instr_ready = 1'b0;
        Reset = 1'b0;
        step(8);
        check("full_req", imem_req, 0);
        instr_ready = 1'b1;
        step(10);

        Reset = 1'b1;
        step(1);
        instr_ready = 1'b0;
        Reset = 1'b0;
        step(4);
        branch_valid = 1'b1;
        branch_target = 8'h40;
        step(1);
        branch_valid = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("br_valid", instr_valid, 0);
        check("br_addr", imem_addr, 8'h40);
        step(12);

        instr_ready = 1'b0;
        step(8);
        #1 Reset = 1'b1;
        #1 check("async_valid", instr_valid, 0);
        step(1);
        Reset = 1'b0;
        instr_ready = 1'b1;
        step(10);

        branch_valid = 1'b1;
        branch_target = 8'hFC;
        step(1);
        branch_valid = 1'b0;
        step(10);

        rp = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rp = (c / 200) % 3 == 0 ? 100 : ((c / 200) % 3 == 1 ? 70 : 30);
            instr_ready = ($urandom_range(0, 99) < rp);
            branch_valid = ($urandom_range(0, 99) < 6);
            branch_target = 8'($urandom);
            if ($urandom_range(0, 999) < 3) begin
                branch_valid = 1'b0;
                Reset = 1'b1;
                step(1);
                Reset = 1'b0;
            end
            step(1);
        end
        branch_valid = 1'b0;
        step(5);

`ifdef PREFETCH_STATS_EN
        branch_valid = 1'b1;
        for (int c = 0; c < 260; c++) begin
            branch_target = 8'($urandom);
            step(1);
        end
        branch_valid = 1'b0;
        step(3);
        check("flush_sat", flush_count, 8'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
